// File: rtl/onehot_decoder_stage_pkg.sv
// Shared definitions for the one-hot decoder stage: code width, occupancy encodings, decode helper.
package onehot_decoder_stage_pkg;

   localparam int OP_L  = 4;
   localparam int OUT_W = 2**OP_L;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_t;

   // Also used by the register-file write-enable and ALU select logic.
   function automatic logic [OUT_W-1:0] onehot(input logic [OP_L-1:0] code, input logic en);
      logic [OUT_W-1:0] w;
      w       = '0;
      w[code] = en;
      return w;
   endfunction

endpackage

// File: rtl/onehot_decoder_stage_if.sv
// Valid/ready bus for the decoder stage: code/enable in, one-hot word and last accepted code out.
interface onehot_decoder_stage_if
   import onehot_decoder_stage_pkg::*;
#(
   parameter int op_L = OP_L
);
   logic                 in_valid;
   logic                 in_ready;
   logic [op_L-1:0]      Din;
   logic                 en;
   logic                 out_valid;
   logic                 out_ready;
   logic [2**op_L-1:0]   Dout;
   logic [op_L-1:0]      last_code;

   modport master (
      output in_valid, Din, en, out_ready,
      input  in_ready, out_valid, Dout, last_code
   );

   modport slave (
      input  in_valid, Din, en, out_ready,
      output in_ready, out_valid, Dout, last_code
   );
endinterface

// File: rtl/onehot_decoder_stage_skid_buffer.sv
// 2-entry skid buffer, 1-cycle latency; in_ready is registered and drops only when both entries are full.
// Exposes the next main-entry value and load/drain strobes so a parent can keep a derived copy in step.
module onehot_decoder_stage_skid_buffer
   import onehot_decoder_stage_pkg::*;
#(
   parameter int WIDTH = OP_L + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_dat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_dat,
   output logic             load_main,
   output logic [WIDTH-1:0] load_dat,
   output logic             drain
);
   occ_t             occ;
   logic [WIDTH-1:0] skid_q;
   logic             in_fire;
   logic             out_fire;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      load_main = 1'b0;
      load_dat  = in_dat;
      drain     = 1'b0;
      case (occ)
         EMPTY: load_main = in_fire;
         ONE: begin
            load_main = in_fire & out_fire;
            drain     = out_fire & ~in_fire;
         end
         TWO: begin
            load_main = out_fire;
            load_dat  = skid_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ       <= EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_dat   <= '0;
         skid_q    <= '0;
      end else begin
         case (occ)
            EMPTY: if (in_fire) begin
               occ       <= ONE;
               out_valid <= 1'b1;
            end
            ONE: if (in_fire && !out_fire) begin
               occ      <= TWO;
               in_ready <= 1'b0;
               skid_q   <= in_dat;
            end else if (out_fire && !in_fire) begin
               occ       <= EMPTY;
               out_valid <= 1'b0;
            end
            TWO: if (out_fire) begin
               occ      <= ONE;
               in_ready <= 1'b1;
            end
            default: begin
               occ       <= EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
         if (load_main) out_dat <= load_dat;
      end
   end
endmodule

// File: rtl/onehot_decoder_stage.sv
// Registered binary->one-hot decoder, 1-cycle latency when the main register is empty or draining.
// Backpressure: holds Dout while stalled, absorbs one extra word in the skid, then drops registered in_ready.
module onehot_decoder_stage
   import onehot_decoder_stage_pkg::*;
#(
   parameter int op_L = OP_L
) (
   input  logic                   clk,
   input  logic                   rst,
   onehot_decoder_stage_if.slave  bus
);
   logic [op_L:0]        main_dat;
   logic [op_L:0]        load_dat;
   logic                 load_main;
   logic                 drain;
   logic                 sb_in_ready;
   logic                 sb_out_valid;
   logic [2**op_L-1:0]   dout_q;
   logic [op_L-1:0]      last_q;
   logic                 unused_en;

   onehot_decoder_stage_skid_buffer #(.WIDTH(op_L + 1)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (bus.in_valid),
      .in_ready  (sb_in_ready),
      .in_dat    ({bus.en, bus.Din}),
      .out_valid (sb_out_valid),
      .out_ready (bus.out_ready),
      .out_dat   (main_dat),
      .load_main (load_main),
      .load_dat  (load_dat),
      .drain     (drain)
   );

   // Decode at load time so Dout comes straight from a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q <= '0;
         last_q <= '0;
      end else begin
         if (load_main)
            dout_q <= onehot(load_dat[op_L-1:0], load_dat[op_L]);
         else if (drain)
            dout_q <= '0;
         if (sb_out_valid && bus.out_ready)
            last_q <= main_dat[op_L-1:0];
      end
   end

   assign unused_en     = main_dat[op_L];
   assign bus.in_ready  = sb_in_ready;
   assign bus.out_valid = sb_out_valid;
   assign bus.Dout      = dout_q;
   assign bus.last_code = last_q;
endmodule
